// File: rtl/serial_deser_if.sv
// Serial deserializer bus: line/acknowledge in, payload and status out.
// master = line driver / consumer side, slave = the deserializer.
interface serial_deser_if #(
    parameter int DATA_W = 7
);
    logic              i_data_in;
    logic              i_ack;
    logic [DATA_W-1:0] o_data_out;
    logic              o_valid;
    logic              o_frame_err;
    logic              o_overrun;
    logic              o_busy;

    modport master (
        output i_data_in, i_ack,
        input  o_data_out, o_valid, o_frame_err, o_overrun, o_busy
    );

    modport slave (
        input  i_data_in, i_ack,
        output o_data_out, o_valid, o_frame_err, o_overrun, o_busy
    );
endinterface

// File: rtl/serial_deser.sv
// Start/data/stop serial deserializer with valid/ack hold and overrun flag.
// Define SERIAL_DESER_PARITY_EN to add an even-parity bit after the payload.
module serial_deser #(
    parameter int DATA_W         = 7,
    parameter int CYCLES_PER_BIT = 1,
    parameter int LSB_FIRST      = 1
) (
    input logic           clk,
    input logic           reset_n,
    serial_deser_if.slave bus
);
    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] LAST     = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF     = CW'(CYCLES_PER_BIT / 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SERIAL_DESER_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bitcnt;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] sh_next;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              frame_err;
    logic              overrun;
    logic              line;
    logic              good;
`ifdef SERIAL_DESER_PARITY_EN
    logic              par_err;
`endif

    assign line = bus.i_data_in;

    // First received bit ends up at bit 0 (LSB_FIRST) or at the MSB.
    assign sh_next = (LSB_FIRST != 0)
        ? ((sh >> 1) | (DATA_W'(line) << (DATA_W - 1)))
        : ((sh << 1) | DATA_W'(line));

`ifdef SERIAL_DESER_PARITY_EN
    assign good = line && !par_err;
`else
    assign good = line;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            sh        <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            if (bus.i_ack && valid)
                valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!line) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF) begin
                        cnt    <= '0;
                        bitcnt <= '0;
                        state  <= line ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        sh     <= sh_next;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT)
`ifdef SERIAL_DESER_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                S_PARITY: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        par_err <= (line != ^sh);
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        if (good) begin
                            data_out <= sh;
                            valid    <= 1'b1;
                            // An ack in this same cycle consumes the old payload.
                            if (valid && !bus.i_ack)
                                overrun <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.o_data_out  = data_out;
    assign bus.o_valid     = valid;
    assign bus.o_frame_err = frame_err;
    assign bus.o_overrun   = overrun;
    assign bus.o_busy      = (state != S_IDLE);
endmodule

// File: tb/tb_serial_deser.sv
// Directed plus random frames against a frame-level model of the deserializer.
// Build with SERIAL_DESER_PARITY_EN defined to exercise the parity bit.
module tb_serial_deser;
    localparam int DW  = 7;
    localparam int CPB = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    serial_deser_if #(.DATA_W(DW)) bus();

    serial_deser #(
        .DATA_W(DW),
        .CYCLES_PER_BIT(CPB),
        .LSB_FIRST(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_ovr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic bitd(input logic b);
        bus.i_data_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        bus.i_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ack = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.i_data_in = 1'b1;
        bus.i_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // One whole frame; ack_last raises i_ack only in the stop-sample cycle.
    task automatic send(input logic [DW-1:0] p, input logic stop_ok,
                        input logic par_ok, input logic ack_last,
                        output logic good);
        bitd(1'b0);
        for (int i = 0; i < DW; i++)
            bitd(p[i]);
`ifdef SERIAL_DESER_PARITY_EN
        bitd((^p) ^ ~par_ok);
`endif
        good = stop_ok && par_ok;
        bus.i_data_in = stop_ok;
        repeat (CPB - 1) @(posedge clk);
        bus.i_ack = ack_last;
        @(posedge clk);
        #1;
        bus.i_ack = 1'b0;
        bus.i_data_in = 1'b1;
        if (good) begin
            if (exp_valid && !ack_last)
                exp_ovr = 1'b1;
            exp_data  = p;
            exp_valid = 1'b1;
        end else if (ack_last) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input logic good);
        chk({tag, ".data"}, 32'(bus.o_data_out), 32'(exp_data));
        chk({tag, ".valid"}, 32'(bus.o_valid), 32'(exp_valid));
        chk({tag, ".ovr"}, 32'(bus.o_overrun), 32'(exp_ovr));
        chk({tag, ".ferr"}, 32'(bus.o_frame_err), 32'(!good));
    endtask

    initial begin
        #3000000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        logic          good;
        logic [DW-1:0] p;
        logic          stop_ok;
        logic          par_ok;
        logic          ack_last;
        int            busy_cnt;

        bus.i_data_in = 1'b1;
        bus.i_ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.data", 32'(bus.o_data_out), 32'd0);
        chk("rst.valid", 32'(bus.o_valid), 32'd0);
        chk("rst.ferr", 32'(bus.o_frame_err), 32'd0);
        chk("rst.ovr", 32'(bus.o_overrun), 32'd0);
        chk("rst.busy", 32'(bus.o_busy), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        send(7'h4A, 1'b1, 1'b1, 1'b0, good);
        check_frame("f4A", good);
        ack_pulse();
        chk("ack.valid", 32'(bus.o_valid), 32'd0);
        chk("ack.data", 32'(bus.o_data_out), 32'h4A);

        bus.i_data_in = 1'b0;
        @(posedge clk);
        #1;
        bus.i_data_in = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.o_busy) busy_cnt++;
            @(posedge clk);
            #1;
        end
        chk("glitch.busy_le3", 32'(busy_cnt >= 1 && busy_cnt <= 3), 32'd1);
        chk("glitch.idle", 32'(bus.o_busy), 32'd0);
        chk("glitch.valid", 32'(bus.o_valid), 32'd0);

        send(7'h55, 1'b0, 1'b1, 1'b0, good);
        check_frame("f55err", good);
        @(posedge clk);
        #1;
        chk("f55err.pulse_end", 32'(bus.o_frame_err), 32'd0);

        send(7'h11, 1'b1, 1'b1, 1'b0, good);
        send(7'h22, 1'b1, 1'b1, 1'b0, good);
        check_frame("ovr", good);
        chk("ovr.data22", 32'(bus.o_data_out), 32'h22);
        chk("ovr.set", 32'(bus.o_overrun), 32'd1);

        do_reset();
        send(7'h11, 1'b1, 1'b1, 1'b0, good);
        ack_pulse();
        send(7'h22, 1'b1, 1'b1, 1'b0, good);
        check_frame("noovr", good);
        chk("noovr.clr", 32'(bus.o_overrun), 32'd0);

        send(7'h33, 1'b1, 1'b1, 1'b1, good);
        check_frame("ackcoin", good);

        bitd(1'b0);
        for (int i = 0; i < 3; i++)
            bitd(1'b1);
        bus.i_data_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("midrst.data", 32'(bus.o_data_out), 32'd0);
        chk("midrst.valid", 32'(bus.o_valid), 32'd0);
        chk("midrst.ovr", 32'(bus.o_overrun), 32'd0);
        chk("midrst.busy", 32'(bus.o_busy), 32'd0);
        repeat (CPB * 10) @(posedge clk);
        #1;
        chk("midrst.noferr", 32'(bus.o_frame_err), 32'd0);
        chk("midrst.novalid", 32'(bus.o_valid), 32'd0);
        send(7'h03, 1'b1, 1'b1, 1'b0, good);
        check_frame("f03", good);

`ifdef SERIAL_DESER_PARITY_EN
        send(7'h07, 1'b1, 1'b1, 1'b0, good);
        check_frame("par_ok", good);
        ack_pulse();
        send(7'h07, 1'b1, 1'b0, 1'b0, good);
        check_frame("par_bad", good);
`endif

        for (int k = 0; k < 24; k++) begin
            if (k == 12) do_reset();
            p        = DW'($urandom);
            stop_ok  = ($urandom_range(0, 5) != 0);
`ifdef SERIAL_DESER_PARITY_EN
            par_ok   = ($urandom_range(0, 4) != 0);
`else
            par_ok   = 1'b1;
`endif
            ack_last = ($urandom_range(0, 3) == 0);
            send(p, stop_ok, par_ok, ack_last, good);
            check_frame($sformatf("rnd%0d", k), good);
            if ($urandom_range(0, 2) == 0) ack_pulse();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
